// File: rtl/mips_data_mem_responder_if.sv
// Request/response bus between the core's load/store unit and the data-memory responder.
// master = core side, slave = responder side.
interface mips_data_mem_responder_if;
    logic        ReqValid;
    logic        ReqWrite;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        ReqReady;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespRData;
    logic        RespError;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, RespReady,
        input  ReqReady, RespValid, RespRData, RespError
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, RespReady,
        output ReqReady, RespValid, RespRData, RespError
    );
endinterface

// File: rtl/mips_data_mem_responder.sv
// Word-organised data RAM answering core load/store requests one at a time.
// Latency: response valid WAIT_STATES+1 cycles after the accept cycle.
// Backpressure: response held stable until RespReady; no request accepted until back in IDLE.
module mips_data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                         Clock,
    input  logic                         Reset,
    mips_data_mem_responder_if.slave     bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              wait_cnt;

    logic                    lat_write;
    logic [31:0]             lat_addr;
    logic [31:0]             lat_wdata;

    logic                    req_acc;
    logic                    enter_resp;
    logic                    eff_write;
    logic [31:0]             eff_addr;
    logic [31:0]             eff_wdata;
    logic                    eff_err;
    logic [ADDR_WIDTH-1:0]   word_idx;

    logic [31:0]             mem [2**ADDR_WIDTH];
    logic [31:0]             resp_rdata;
    logic                    resp_error;

    assign req_acc    = (state == ST_IDLE) && bus.ReqValid;
    assign enter_resp = (state != ST_RESP) && (state_nxt == ST_RESP);

    // With zero wait states RESP is entered straight from IDLE, before the
    // request has been latched, so the access uses the live request fields.
    assign eff_write = (state == ST_IDLE) ? bus.ReqWrite : lat_write;
    assign eff_addr  = (state == ST_IDLE) ? bus.ReqAddr  : lat_addr;
    assign eff_wdata = (state == ST_IDLE) ? bus.ReqWData : lat_wdata;
    assign eff_err   = (eff_addr[1:0] != 2'b00) || ((eff_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign word_idx  = eff_addr[ADDR_WIDTH+1:2];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.ReqValid) begin
                    state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.RespReady) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ReqReady  = (state == ST_IDLE);
        bus.RespValid = (state == ST_RESP);
        bus.RespRData = resp_rdata;
        bus.RespError = resp_error;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_cnt  <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else if (req_acc) begin
            wait_cnt  <= WAIT_INIT;
            lat_write <= bus.ReqWrite;
            lat_addr  <= bus.ReqAddr;
            lat_wdata <= bus.ReqWData;
        end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else if (enter_resp) begin
            resp_error <= eff_err;
            resp_rdata <= (eff_write || eff_err) ? 32'd0 : mem[word_idx];
        end
    end

    // RAM contents survive Reset; a store caught by Reset before RESP is dropped.
    always_ff @(posedge Clock) begin
        if (!Reset && enter_resp && eff_write && !eff_err) begin
            mem[word_idx] <= eff_wdata;
        end
    end

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Bench for mips_data_mem_responder: WAIT_STATES=2 instance plus a WAIT_STATES=0 instance.
module tb_mips_data_mem_responder;

    localparam int WS_A = 2;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    mips_data_mem_responder_if bus();
    mips_data_mem_responder_if bus0();

    mips_data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(WS_A)) dut_a (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    mips_data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_b (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus0.slave)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sbq_a[$];
    exp_t        sbq_b[$];
    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];

    // Reference behaviour: 256 words, byte addresses 0..1023, word aligned only.
    function automatic exp_t model_req(bit use_b, bit wr, logic [31:0] addr, logic [31:0] wd);
        exp_t e;
        bit   bad;
        int   key;
        bad     = (addr % 4 != 0) || (addr >= 32'd1024);
        key     = int'(addr >> 2);
        e.err   = bad;
        e.rdata = 32'd0;
        if (!bad) begin
            if (wr) begin
                if (use_b) mem_b[key] = wd;
                else       mem_a[key] = wd;
            end else begin
                if (use_b) e.rdata = mem_b.exists(key) ? mem_b[key] : 32'hxxxxxxxx;
                else       e.rdata = mem_a.exists(key) ? mem_a[key] : 32'hxxxxxxxx;
            end
        end
        return e;
    endfunction

    // One transaction on dut_a; optional RespReady hold and input scrambling during WAIT.
    task automatic transact(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            input int hold, input bit scramble, input string name);
        exp_t e;
        int   lat;
        int   t;
        @(negedge Clock);
        t = 0;
        while (bus.ReqReady !== 1'b1 && t < 50) begin
            @(negedge Clock);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL %s ready_timeout ReqReady=%b required 1", name, bus.ReqReady);
            return;
        end
        sbq_a.push_back(model_req(1'b0, wr, addr, wd));
        bus.ReqValid = 1'b1;
        bus.ReqWrite = wr;
        bus.ReqAddr  = addr;
        bus.ReqWData = wd;
        @(posedge Clock);
        #1;
        bus.ReqValid = 1'b0;
        lat = 1;
        for (t = 0; t < 50; t++) begin
            @(negedge Clock);
            if (bus.RespValid === 1'b1) break;
            lat++;
            if (scramble) begin
                bus.ReqValid = 1'b1;
                bus.ReqWrite = 1'b1;
                bus.ReqAddr  = 32'h20;
                bus.ReqWData = $urandom;
            end
        end
        bus.ReqValid = 1'b0;
        n_cmp++;
        if (t >= 50) begin
            n_err++;
            $display("FAIL %s resp_timeout RespValid never rose", name);
            void'(sbq_a.pop_front());
            return;
        end
        if (lat !== WS_A + 1) begin
            n_err++;
            $display("FAIL %s latency got %0d required %0d", name, lat, WS_A + 1);
        end
        e = sbq_a.pop_front();
        n_cmp++;
        if (bus.RespRData !== e.rdata) begin
            n_err++;
            $display("FAIL %s rdata got %h required %h", name, bus.RespRData, e.rdata);
        end
        n_cmp++;
        if (bus.RespError !== e.err) begin
            n_err++;
            $display("FAIL %s error got %b required %b", name, bus.RespError, e.err);
        end
        for (int h = 0; h < hold; h++) begin
            bus.ReqValid = (h % 2 == 0);
            bus.ReqWrite = 1'b1;
            bus.ReqAddr  = 32'h0;
            bus.ReqWData = 32'hFFFFFFFF;
            @(negedge Clock);
            n_cmp++;
            if (bus.RespValid !== 1'b1 || bus.RespRData !== e.rdata ||
                bus.RespError !== e.err || bus.ReqReady !== 1'b0) begin
                n_err++;
                $display("FAIL %s hold%0d valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                         name, h, bus.RespValid, bus.RespRData, bus.RespError, bus.ReqReady,
                         e.rdata, e.err);
            end
        end
        bus.ReqValid = 1'b0;
        n_cmp++;
        if (bus.ReqReady !== 1'b0) begin
            n_err++;
            $display("FAIL %s ready_in_handshake got %b required 0", name, bus.ReqReady);
        end
        bus.RespReady = 1'b1;
        @(posedge Clock);
        #1;
        bus.RespReady = 1'b0;
        @(negedge Clock);
        n_cmp++;
        if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_handshake ready=%b valid=%b required 1 0",
                     name, bus.ReqReady, bus.RespValid);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        n_cmp++;
        if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0 ||
            bus.RespRData !== 32'd0 || bus.RespError !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                     bus.ReqReady, bus.RespValid, bus.RespRData, bus.RespError);
        end
        n_cmp++;
        if (bus0.ReqReady !== 1'b1 || bus0.RespValid !== 1'b0 ||
            bus0.RespRData !== 32'd0 || bus0.RespError !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                     bus0.ReqReady, bus0.RespValid, bus0.RespRData, bus0.RespError);
        end
        Reset = 1'b0;
    endtask

    task automatic test_store_load();
        transact(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, "store_10");
        transact(1'b0, 32'h10, 32'h0,        0, 1'b0, "load_10");
        transact(1'b1, 32'h00, 32'h0BADF00D, 0, 1'b0, "pre_w0");
        transact(1'b1, 32'h04, 32'h12345678, 0, 1'b0, "pre_w1");
        transact(1'b1, 32'h08, 32'h11111111, 0, 1'b0, "pre_w2");
        transact(1'b1, 32'h20, 32'h55AA55AA, 0, 1'b0, "pre_w8");
    endtask

    task automatic test_errors();
        transact(1'b0, 32'h13,  32'h0,        0, 1'b0, "misaligned_load");
        transact(1'b1, 32'h400, 32'hCAFEF00D, 0, 1'b0, "range_store");
        transact(1'b0, 32'h00,  32'h0,        0, 1'b0, "word0_intact");
    endtask

    task automatic test_backpressure();
        transact(1'b0, 32'h04, 32'h0, 5, 1'b0, "hold_load_4");
        transact(1'b0, 32'h00, 32'h0, 0, 1'b0, "pulses_ignored");
    endtask

    task automatic test_reset_mid();
        transact(1'b0, 32'h08, 32'h0, 0, 1'b0, "load_8_before");
        @(negedge Clock);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b1;
        bus.ReqAddr  = 32'h08;
        bus.ReqWData = 32'hA5A5A5A5;
        @(posedge Clock);
        #1;
        bus.ReqValid = 1'b0;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        n_cmp++;
        if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0 ||
            bus.RespRData !== 32'd0 || bus.RespError !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                     bus.ReqReady, bus.RespValid, bus.RespRData, bus.RespError);
        end
        transact(1'b0, 32'h08, 32'h0, 0, 1'b0, "load_8_after");
    endtask

    task automatic test_scramble();
        transact(1'b1, 32'h0C, 32'h0C0C0C0C, 0, 1'b1, "scramble_store");
        transact(1'b0, 32'h0C, 32'h0,        0, 1'b0, "load_c");
        transact(1'b0, 32'h20, 32'h0,        0, 1'b0, "load_20_intact");
    endtask

    // dut_b: ReqValid held high, RespReady tied high; accept/response alternate.
    task automatic b_stream(input bit wr, input int n, input string name);
        exp_t e;
        int   acc;
        acc = 0;
        @(negedge Clock);
        bus0.ReqValid = 1'b1;
        bus0.ReqWrite = wr;
        bus0.ReqAddr  = 32'h40;
        bus0.ReqWData = 32'hB0000000;
        for (int cyc = 0; cyc < 2 * n; cyc++) begin
            n_cmp++;
            if (bus0.ReqReady !== (cyc % 2 == 0) || bus0.RespValid !== (cyc % 2 == 1)) begin
                n_err++;
                $display("FAIL %s toggle cyc%0d ready=%b valid=%b required %b %b", name, cyc,
                         bus0.ReqReady, bus0.RespValid, cyc % 2 == 0, cyc % 2 == 1);
            end
            if (bus0.RespValid === 1'b1 && sbq_b.size() > 0) begin
                e = sbq_b.pop_front();
                n_cmp++;
                if (bus0.RespRData !== e.rdata || bus0.RespError !== e.err) begin
                    n_err++;
                    $display("FAIL %s resp cyc%0d rdata=%h err=%b required %h %b", name, cyc,
                             bus0.RespRData, bus0.RespError, e.rdata, e.err);
                end
            end
            if (bus0.ReqReady === 1'b1 && bus0.ReqValid === 1'b1) begin
                sbq_b.push_back(model_req(1'b1, wr, bus0.ReqAddr, bus0.ReqWData));
                acc++;
            end
            @(posedge Clock);
            #1;
            if (acc == n) bus0.ReqValid = 1'b0;
            bus0.ReqAddr  = 32'h40 + 32'(4 * acc);
            bus0.ReqWData = 32'hB0000000 + 32'(acc);
            @(negedge Clock);
        end
        bus0.ReqValid = 1'b0;
        n_cmp++;
        if (sbq_b.size() != 0) begin
            n_err++;
            $display("FAIL %s leftover responses got %0d required 0", name, sbq_b.size());
            sbq_b.delete();
        end
    endtask

    task automatic test_ws0();
        b_stream(1'b1, 4, "ws0_stores");
        b_stream(1'b0, 4, "ws0_loads");
    endtask

    initial begin
        bus.ReqValid   = 1'b0;
        bus.ReqWrite   = 1'b0;
        bus.ReqAddr    = 32'h0;
        bus.ReqWData   = 32'h0;
        bus.RespReady  = 1'b0;
        bus0.ReqValid  = 1'b0;
        bus0.ReqWrite  = 1'b0;
        bus0.ReqAddr   = 32'h0;
        bus0.ReqWData  = 32'h0;
        bus0.RespReady = 1'b1;
        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_scramble();
        test_ws0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
